// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the multicycle data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } stateT;

    localparam int unsigned DefDepth      = 1024;
    localparam logic [31:0] DefBaseAddr   = 32'h0000_0400;
    localparam int unsigned DefWaitCycles = 2;

    localparam logic AccLoad  = 1'b0;
    localparam logic AccStore = 1'b1;
    localparam logic AccWord  = 1'b0;
    localparam logic AccByte  = 1'b1;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor-side memory port: request strobe and access fields in, response out.
interface data_mem_responder_if;

    logic        Req;
    logic        We;
    logic        Byte;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic        Ready;
    logic [31:0] RdData;
    logic        Err;
    logic        Busy;

    modport master (
        output Req, We, Byte, Addr, WrData,
        input  Ready, RdData, Err, Busy
    );

    modport slave (
        input  Req, We, Byte, Addr, WrData,
        output Ready, RdData, Err, Busy
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and registered read data.
module data_mem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic [IdxW-1:0] index,
    input  logic [3:0]      byteEn,
    input  logic [31:0]     wrData,
    output logic [31:0]     rdData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
                mem[index][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
        rdData <= mem[index];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: captures a load/store, waits WAIT_CYCLES, then
// pulses Ready with the result; misaligned or out-of-range accesses flag Err.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DefDepth,
    parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input logic                 Clk,
    input logic                 Reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    stateT       state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        reqWe_q, reqByte_q;
    logic [31:0] reqAddr_q, reqWrData_q;
    logic [31:0] rdHold_q;

    logic [31:0]     offset;
    logic [1:0]      lane;
    logic            outOfRange, misaligned, accErr;
    logic [IdxW-1:0] ramIdx;
    logic [3:0]      byteEn;
    logic [31:0]     ramWrData, ramRdData, result;

    assign offset     = reqAddr_q - BASE_ADDR;
    assign lane       = offset[1:0];
    // Addresses below BASE_ADDR wrap to huge offsets and land here too.
    assign outOfRange = |offset[31:IdxW+2];
    assign misaligned = (reqByte_q == AccWord) && (lane != 2'd0);
    assign accErr     = outOfRange | misaligned;

    // In IDLE the RAM reads the live address so data is ready even with zero wait states.
    always_comb begin
        ramIdx = IdxW'(offset >> 2);
        if (state_q == StIdle) begin
            ramIdx = IdxW'((bus.Addr - BASE_ADDR) >> 2);
        end
    end

    always_comb begin
        byteEn    = 4'b0000;
        ramWrData = reqWrData_q;
        if (reqByte_q == AccByte) begin
            ramWrData = {4{reqWrData_q[7:0]}};
        end
        if (state_q == StResp && reqWe_q == AccStore && !accErr && Reset) begin
            byteEn = (reqByte_q == AccByte) ? (4'b0001 << lane) : 4'b1111;
        end
    end

    always_comb begin
        result = ramRdData;
        if (reqByte_q == AccByte) begin
            result = {24'b0, ramRdData[{lane, 3'b000} +: 8]};
        end
        if (accErr || reqWe_q == AccStore) begin
            result = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            reqWe_q     <= 1'b0;
            reqByte_q   <= 1'b0;
            reqAddr_q   <= 32'h0;
            reqWrData_q <= 32'h0;
            rdHold_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && bus.Req) begin
                reqWe_q     <= bus.We;
                reqByte_q   <= bus.Byte;
                reqAddr_q   <= bus.Addr;
                reqWrData_q <= bus.WrData;
            end
            if (state_q == StResp) begin
                rdHold_q <= result;
            end
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_array (
        .clk    (Clk),
        .index  (ramIdx),
        .byteEn (byteEn),
        .wrData (ramWrData),
        .rdData (ramRdData)
    );

    assign bus.Ready  = (state_q == StResp);
    assign bus.RdData = (state_q == StResp) ? result : rdHold_q;
    assign bus.Err    = (state_q == StResp) && accErr;
    assign bus.Busy   = (state_q != StIdle);

endmodule
